// File: rtl/vga_pixel_out_if.sv
// vga_pixel_out_if: frame-buffer read port and VGA pin bundle of the VGA output stage.
interface vga_pixel_out_if #(parameter int ADDR_W = 17);
   logic [11:0]       pixel_in;
   logic [ADDR_W-1:0] fb_addr;
   logic              fb_rd_en;
   logic [3:0]        vga_r;
   logic [3:0]        vga_g;
   logic [3:0]        vga_b;
   logic              vga_hs;
   logic              vga_vs;
   logic              frame_start;
   modport master (input pixel_in, output fb_addr, fb_rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start);
   modport slave (output pixel_in, input fb_addr, fb_rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start);
endinterface

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA timing, frame-buffer addressing and latency-aligned RGB444/sync output.
module vga_pixel_out #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          IMG_W    = 320,
   parameter int          IMG_H    = 240,
   parameter int          ADDR_W   = 17,
   parameter int          RD_LAT   = 1,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input logic             clk,
   input logic             rst,
   vga_pixel_out_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int LAST    = IMG_W * IMG_H - 1;
   localparam logic [4:0] DL_IDLE = 5'b00110;

   if (IMG_W > H_ACTIVE || IMG_H > V_ACTIVE || RD_LAT < 1 ||
       longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_params
      $fatal(1, "vga_pixel_out: invalid parameter combination");
   end

   logic [HW-1:0]     r_hc;
   logic [VW-1:0]     r_vc;
   logic [ADDR_W-1:0] r_fb_addr;
   logic              r_fb_rd_en;
   logic [4:0]        r_dl [RD_LAT];
   logic [11:0]       r_rgb;
   logic              r_hs;
   logic              r_vs;
   logic              r_fs;

   logic              w_h_end;
   logic              w_v_end;
   logic [HW-1:0]     w_hc_n;
   logic [VW-1:0]     w_vc_n;
   logic              w_act;
   logic              w_img;
   logic              w_img_n;
   logic              w_hs;
   logic              w_vs;
   logic              w_fs;
   logic [ADDR_W-1:0] w_addr_n;
   logic [4:0]        w_d;

   always_comb begin
      w_h_end  = r_hc == HW'(H_TOTAL - 1);
      w_v_end  = r_vc == VW'(V_TOTAL - 1);
      w_hc_n   = w_h_end ? '0 : r_hc + 1'b1;
      w_vc_n   = w_h_end ? (w_v_end ? '0 : r_vc + 1'b1) : r_vc;
      w_act    = r_hc < HW'(H_ACTIVE) && r_vc < VW'(V_ACTIVE);
      w_img    = r_hc < HW'(IMG_W) && r_vc < VW'(IMG_H);
      w_img_n  = w_hc_n < HW'(IMG_W) && w_vc_n < VW'(IMG_H);
      w_hs     = !(r_hc >= HW'(H_ACTIVE + H_FP) && r_hc < HW'(H_ACTIVE + H_FP + H_SYNC));
      w_vs     = !(r_vc >= VW'(V_ACTIVE + V_FP) && r_vc < VW'(V_ACTIVE + V_FP + V_SYNC));
      w_fs     = r_hc == '0 && r_vc == '0;
      // address/rd_en are registered from the next counter value so they line up with hc/vc
      w_addr_n = (w_hc_n == '0 && w_vc_n == '0) ? '0 :
                 r_fb_addr + ADDR_W'(w_img && r_fb_addr != ADDR_W'(LAST));
      w_d      = r_dl[RD_LAT-1];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_hc       <= '0;
         r_vc       <= '0;
         r_fb_addr  <= '0;
         r_fb_rd_en <= 1'b0;
      end else begin
         r_hc       <= w_hc_n;
         r_vc       <= w_vc_n;
         r_fb_addr  <= w_addr_n;
         r_fb_rd_en <= w_img_n;
      end

   // delay line bits: {active, in_img, hs, vs, frame_start}
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) r_dl[i] <= DL_IDLE;
         r_rgb <= 12'h000;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_fs  <= 1'b0;
      end else begin
         r_dl[0] <= {w_act, w_img, w_hs, w_vs, w_fs};
         for (int i = 1; i < RD_LAT; i++) r_dl[i] <= r_dl[i-1];
         r_rgb <= w_d[3] ? bus.pixel_in : (w_d[4] ? BG_COLOR : 12'h000);
         r_hs  <= w_d[2];
         r_vs  <= w_d[1];
         r_fs  <= w_d[0];
      end

   assign bus.fb_addr     = r_fb_addr;
   assign bus.fb_rd_en    = r_fb_rd_en;
   assign bus.vga_r       = r_rgb[11:8];
   assign bus.vga_g       = r_rgb[7:4];
   assign bus.vga_b       = r_rgb[3:0];
   assign bus.vga_hs      = r_hs;
   assign bus.vga_vs      = r_vs;
   assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: directed checks of two scaled-down VGA output stages (RD_LAT 1 windowed, RD_LAT 3 full-width).
module tb_vga_pixel_out;
   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam logic [14:0] RST_PINS = 15'b000000000000_110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0, n_err = 0, k = 0;
   int   fs_a = -1, fs2_a = -1, fs_b = -1;
   int   rden_a = 0, rden_b = 0, hs_lo = 0, vs_lo = 0;

   always #5 clk = ~clk;

   vga_pixel_out_if #(.ADDR_W(6)) ia();
   vga_pixel_out_if #(.ADDR_W(7)) ib();

   vga_pixel_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .IMG_W(10), .IMG_H(6), .ADDR_W(6), .RD_LAT(1), .BG_COLOR(12'h5A3))
      ua (.clk(clk), .rst(rst), .bus(ia));

   vga_pixel_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .IMG_W(16), .IMG_H(8), .ADDR_W(7), .RD_LAT(3), .BG_COLOR(12'hF0F))
      ub (.clk(clk), .rst(rst), .bus(ib));

   function automatic logic [11:0] mem_f(input int a);
      return 12'(a * 149 + 7);
   endfunction

   // frame buffer + scramble models: registered read, then RD_LAT-1 extra stages
   logic [11:0] pa;
   logic [11:0] pb [3];
   always @(posedge clk) begin
      pa    <= mem_f(int'(ia.fb_addr));
      pb[0] <= mem_f(int'(ib.fb_addr));
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign ia.pixel_in = pa;
   assign ib.pixel_in = pb[2];

   function automatic logic [14:0] exp_pins(input int p, input int iw, input int ih, input logic [11:0] bg);
      int x, y;
      logic [11:0] c;
      x = p % HT;
      y = p / HT;
      c = (x < iw && y < ih) ? mem_f(y * iw + x) : ((x < HA && y < VA) ? bg : 12'h000);
      return {c, !(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS), p == 0};
   endfunction

   function automatic logic [7:0] exp_bus(input int p, input int iw, input int ih);
      int x, y, c;
      x = p % HT;
      y = p / HT;
      c = y * iw + (x < iw ? x : iw);
      if (c > iw * ih - 1) c = iw * ih - 1;
      return {x < iw && y < ih, 7'(c)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s k=%0d got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   task automatic check_cycle();
      logic [14:0] pins_a, pins_b;
      pins_a = {ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_hs, ia.vga_vs, ia.frame_start};
      pins_b = {ib.vga_r, ib.vga_g, ib.vga_b, ib.vga_hs, ib.vga_vs, ib.frame_start};
      if (k >= 1) begin
         chk("a_bus", {ia.fb_rd_en, 1'b0, ia.fb_addr}, exp_bus(k % FR, 10, 6));
         chk("b_bus", {ib.fb_rd_en, ib.fb_addr}, exp_bus(k % FR, 16, 8));
      end
      chk("a_pins", pins_a, k < 2 ? RST_PINS : exp_pins((k - 2) % FR, 10, 6, 12'h5A3));
      chk("b_pins", pins_b, k < 4 ? RST_PINS : exp_pins((k - 4) % FR, 16, 8, 12'hF0F));
      if (ia.frame_start && fs_a >= 0 && fs2_a < 0) fs2_a = k;
      if (ia.frame_start && fs_a < 0) fs_a = k;
      if (ib.frame_start && fs_b < 0) fs_b = k;
      if (k >= 1 && k <= FR) begin
         rden_a += int'(ia.fb_rd_en);
         rden_b += int'(ib.fb_rd_en);
      end
      if (k >= 2 && k < 2 + FR) begin
         hs_lo += int'(!ia.vga_hs);
         vs_lo += int'(!ia.vga_vs);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      k++;
   endtask

   task automatic chk_reset_pins(input string tag);
      chk({tag, "_a_pins"}, {ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_hs, ia.vga_vs, ia.frame_start}, RST_PINS);
      chk({tag, "_b_pins"}, {ib.vga_r, ib.vga_g, ib.vga_b, ib.vga_hs, ib.vga_vs, ib.frame_start}, RST_PINS);
      chk({tag, "_a_bus"}, {ia.fb_rd_en, ia.fb_addr}, 0);
      chk({tag, "_b_bus"}, {ib.fb_rd_en, ib.fb_addr}, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_pins("por");
      rst = 1'b0;
      k = 0;
      repeat (2 * FR + 6) step();
      chk("a_fs_first", fs_a, 2);
      chk("a_fs_period", fs2_a - fs_a, FR);
      chk("b_fs_first", fs_b, 4);
      chk("a_rden_frame", rden_a, 60);
      chk("b_rden_frame", rden_b, 128);
      chk("a_hs_low_cnt", hs_lo, HS * VT);
      chk("a_vs_low_cnt", vs_lo, VS * HT);
      while (k % FR != 4 * HT + 12) step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_pins("mid");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      k = 0;
      fs_a = -1;
      fs2_a = -1;
      fs_b = -1;
      repeat (FR + 6) step();
      chk("a_fs_after_rst", fs_a, 2);
      chk("b_fs_after_rst", fs_b, 4);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
